// File: rtl/lfsr_pkg.sv
// lfsr_pkg: constants shared by the 64-bit Fibonacci PRBS generator and checker.
//   LFSR_WIDTH        register length
//   TAP_*             feedback tap indices (r[0] holds the newest bit, MSB shifts out)
//   ST_HUNT/ST_CHECK  checker state encoding
//   lfsr_fb()         feedback / next-bit prediction from a full register
package lfsr_pkg;

  localparam int unsigned LFSR_WIDTH = 64;

  localparam int unsigned TAP_A = 59;
  localparam int unsigned TAP_B = 60;
  localparam int unsigned TAP_C = 62;
  localparam int unsigned TAP_D = 63;

  localparam logic [0:0] ST_HUNT  = 1'b0;
  localparam logic [0:0] ST_CHECK = 1'b1;

  function automatic logic lfsr_fb(input logic [LFSR_WIDTH-1:0] r);
    return r[TAP_A] ^ r[TAP_B] ^ r[TAP_C] ^ r[TAP_D];
  endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// lfsr_sat_counter: up-counter that sticks at all-ones.
//   CLK    clock
//   RST    synchronous reset, active-high
//   inc    count up by one this cycle (ignored once saturated)
//   clr    synchronous clear, wins over inc
//   count  current value
module lfsr_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/lfsr_prbs_checker.sv
// lfsr_prbs_checker: receive-side checker for the 64-bit Fibonacci PRBS stream.
// Loads 64 received bits to seed a local LFSR, then free-runs it and compares every
// further accepted bit with the prediction. Too many errors in one window drop lock.
//   CLK        clock
//   RST        synchronous reset, active-high
//   BIT_EN     RX_BIT valid this cycle
//   RX_BIT     received stream bit
//   CLR_STATS  clear statistics counters
//   LOCKED     checker is in CHECK state
//   ERR_PULSE  one-cycle strobe: last accepted bit mismatched
//   ERR_COUNT  saturating mismatch count
//   BIT_COUNT  saturating count of bits checked while locked
// Build option: define LFSR_CHK_STATS_EN to build ERR_COUNT/BIT_COUNT; otherwise both
// read 0 and CLR_STATS is ignored.
import lfsr_pkg::*;

module lfsr_prbs_checker #(
  parameter int unsigned LOSS_WINDOW = 256,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BIT_EN,
  input  logic             RX_BIT,
  input  logic             CLR_STATS,
  output logic             LOCKED,
  output logic             ERR_PULSE,
  output logic [CNT_W-1:0] ERR_COUNT,
  output logic [CNT_W-1:0] BIT_COUNT
);

  localparam int unsigned FILL_W = $clog2(LFSR_WIDTH + 1);
  localparam int unsigned WB_W   = $clog2(LOSS_WINDOW + 1);
  localparam int unsigned WE_W   = $clog2(LOSS_THRESH + 1);

  logic [0:0]            state_q, state_d;
  logic [LFSR_WIDTH-1:0] r_q, r_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [WB_W-1:0]       win_bits_q, win_bits_d, win_bits_inc;
  logic [WE_W-1:0]       win_err_q, win_err_d, win_err_inc;
  logic                  err_q, err_d;
  logic                  pred;
  logic                  mism;

  assign pred         = lfsr_fb(r_q);
  assign mism         = RX_BIT ^ pred;
  assign win_bits_inc = win_bits_q + WB_W'(1);
  assign win_err_inc  = win_err_q + WE_W'(mism);

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    fill_d     = fill_q;
    win_bits_d = win_bits_q;
    win_err_d  = win_err_q;
    err_d      = 1'b0;
    if (BIT_EN) begin
      if (state_q == ST_HUNT) begin
        r_d = {r_q[LFSR_WIDTH-2:0], RX_BIT};
        if (fill_q == FILL_W'(LFSR_WIDTH - 1)) begin
          fill_d = '0;
          // An all-zero seed is the LFSR lock-up state; keep hunting.
          if (r_d != '0) begin
            state_d = ST_CHECK;
          end
        end else begin
          fill_d = fill_q + FILL_W'(1);
        end
      end else begin
        // Shift the prediction, not the received bit, so a channel error is not
        // propagated into later predictions.
        r_d   = {r_q[LFSR_WIDTH-2:0], pred};
        err_d = mism;
        if (win_err_inc == WE_W'(LOSS_THRESH)) begin
          state_d    = ST_HUNT;
          fill_d     = '0;
          win_bits_d = '0;
          win_err_d  = '0;
        end else if (win_bits_inc == WB_W'(LOSS_WINDOW)) begin
          win_bits_d = '0;
          win_err_d  = '0;
        end else begin
          win_bits_d = win_bits_inc;
          win_err_d  = win_err_inc;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_HUNT;
      r_q        <= '0;
      fill_q     <= '0;
      win_bits_q <= '0;
      win_err_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      fill_q     <= fill_d;
      win_bits_q <= win_bits_d;
      win_err_q  <= win_err_d;
      err_q      <= err_d;
    end
  end

  assign LOCKED    = (state_q == ST_CHECK);
  assign ERR_PULSE = err_q;

`ifdef LFSR_CHK_STATS_EN
  logic chk_acc;
  assign chk_acc = BIT_EN && (state_q == ST_CHECK);

  lfsr_sat_counter #(
    .WIDTH(CNT_W)
  ) u_err_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (chk_acc && mism),
    .clr  (CLR_STATS),
    .count(ERR_COUNT)
  );

  lfsr_sat_counter #(
    .WIDTH(CNT_W)
  ) u_bit_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (chk_acc),
    .clr  (CLR_STATS),
    .count(BIT_COUNT)
  );
`else
  logic unused_clr_stats;
  assign unused_clr_stats = CLR_STATS;
  assign ERR_COUNT        = '0;
  assign BIT_COUNT        = '0;
`endif

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Bench for lfsr_prbs_checker: two instances (default parameters, and a 4-bit-counter
// variant with a high loss threshold) share one stimulus stream. A reference model of
// the checking rules, built on a circular bit history, queues the expected outputs per
// cycle; a monitor pops and compares them one cycle later.
module tb_lfsr_prbs_checker;

`ifdef LFSR_CHK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1, BIT_EN = 1'b0, RX_BIT = 1'b0, CLR_STATS = 1'b0;
  logic l0, p0, l1, p1;
  logic [15:0] ec0, bc0;
  logic [3:0]  ec1, bc1;

  always #5 CLK = ~CLK;

  lfsr_prbs_checker dut (
    .CLK(CLK), .RST(RST), .BIT_EN(BIT_EN), .RX_BIT(RX_BIT), .CLR_STATS(CLR_STATS),
    .LOCKED(l0), .ERR_PULSE(p0), .ERR_COUNT(ec0), .BIT_COUNT(bc0)
  );

  lfsr_prbs_checker #(
    .LOSS_WINDOW(256), .LOSS_THRESH(255), .CNT_W(4)
  ) dut_s (
    .CLK(CLK), .RST(RST), .BIT_EN(BIT_EN), .RX_BIT(RX_BIT), .CLR_STATS(CLR_STATS),
    .LOCKED(l1), .ERR_PULSE(p1), .ERR_COUNT(ec1), .BIT_COUNT(bc1)
  );

  typedef struct packed {
    logic        locked;
    logic        err;
    logic [15:0] ec;
    logic [15:0] bc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  int   pulses0 = 0, pulses1 = 0;
  bit   locked_seen0 = 0;

  // Reference model state, index 0 = dut, 1 = dut_s.
  bit hist[2][64];
  int wp[2], fill[2], wbits[2], werr[2], ecnt[2], bcnt[2];
  bit lk[2];

  function automatic int thr(input int m);
    return (m == 0) ? 8 : 255;
  endfunction

  function automatic int cmax(input int m);
    return (m == 0) ? 65535 : 15;
  endfunction

  // Bit received/predicted k steps ago (k=1 is the most recent).
  function automatic bit past(input int m, input int k);
    return hist[m][(wp[m] - k + 64) % 64];
  endfunction

  task automatic push_hist(input int m, input bit b);
    hist[m][wp[m]] = b;
    wp[m] = (wp[m] + 1) % 64;
  endtask

  task automatic model_step(input int m, input bit rst, input bit en, input bit rx,
                            input bit clr, output exp_t e);
    bit mis = 1'b0;
    bit nz;
    bit p;
    if (rst) begin
      for (int i = 0; i < 64; i++) hist[m][i] = 1'b0;
      wp[m] = 0; fill[m] = 0; wbits[m] = 0; werr[m] = 0; ecnt[m] = 0; bcnt[m] = 0;
      lk[m] = 1'b0;
    end else begin
      if (en && !lk[m]) begin
        push_hist(m, rx);
        fill[m]++;
        if (fill[m] == 64) begin
          fill[m] = 0;
          nz = 1'b0;
          for (int i = 0; i < 64; i++) nz |= hist[m][i];
          lk[m] = nz;
        end
      end else if (en) begin
        // x[n] = x[n-60] ^ x[n-61] ^ x[n-63] ^ x[n-64]
        p   = past(m, 60) ^ past(m, 61) ^ past(m, 63) ^ past(m, 64);
        mis = (rx != p);
        push_hist(m, p);
        if (STATS) begin
          if (bcnt[m] < cmax(m)) bcnt[m]++;
          if (mis && ecnt[m] < cmax(m)) ecnt[m]++;
        end
        wbits[m]++;
        werr[m] += int'(mis);
        if (werr[m] == thr(m)) begin
          lk[m] = 1'b0; fill[m] = 0; wbits[m] = 0; werr[m] = 0;
        end else if (wbits[m] == 256) begin
          wbits[m] = 0; werr[m] = 0;
        end
      end
      if (clr && STATS) begin
        ecnt[m] = 0;
        bcnt[m] = 0;
      end
    end
    e.locked = lk[m];
    e.err    = mis;
    e.ec     = 16'(ecnt[m]);
    e.bc     = 16'(bcnt[m]);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; returns 2 time units after the edge it was applied to.
  task automatic step(input bit rst, input bit en, input bit rx, input bit clr);
    exp_t e0, e1;
    RST = rst; BIT_EN = en; RX_BIT = rx; CLR_STATS = clr;
    model_step(0, rst, en, rx, clr, e0);
    model_step(1, rst, en, rx, clr, e1);
    q0.push_back(e0);
    q1.push_back(e1);
    @(posedge CLK);
    #2;
  endtask

  logic [63:0] g;

  task automatic gen_reset();
    g = 64'hACE1;
  endtask

  task automatic send(input bit inv, input bit clr);
    bit b;
    b = g[63];
    g = {g[62:0], g[63] ^ g[62] ^ g[60] ^ g[59]};
    step(1'b0, 1'b1, b ^ inv, clr);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    pulses0 = 0; pulses1 = 0; locked_seen0 = 1'b0;
  endtask

  // Monitor: outputs settle after each edge; compare against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("locked0", 32'(l0), 32'(e.locked));
        check("pulse0", 32'(p0), 32'(e.err));
        check("errcnt0", 32'(ec0), 32'(e.ec));
        check("bitcnt0", 32'(bc0), 32'(e.bc));
        if (p0) pulses0++;
        if (l0) locked_seen0 = 1'b1;
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("locked1", 32'(l1), 32'(e.locked));
        check("pulse1", 32'(p1), 32'(e.err));
        check("errcnt1", 32'(ec1), 32'(e.ec));
        check("bitcnt1", 32'(bc1), 32'(e.bc));
        if (p1) pulses1++;
      end
    end
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_locked", 32'(l0), 32'd0);
    check("rst_pulse", 32'(p0), 32'd0);
    check("rst_cnt", 32'({ec0, bc0}), 32'd0);

    // 1: clean stream, lock after bit 64
    gen_reset();
    for (int i = 1; i <= 1000; i++) begin
      send(1'b0, 1'b0);
      if (i == 63) check("t1_not_yet", 32'(l0), 32'd0);
      if (i == 64) check("t1_lock", 32'(l0), 32'd1);
    end
    check("t1_pulses", 32'(pulses0), 32'd0);
    check("t1_errcnt", 32'(ec0), 32'd0);
    check("t1_bitcnt", 32'(bc0), STATS ? 32'd936 : 32'd0);

    // 2: single error at bit 500
    do_reset();
    gen_reset();
    for (int i = 1; i <= 1000; i++) send(i == 500, 1'b0);
    check("t2_pulses", 32'(pulses0), 32'd1);
    check("t2_errcnt", 32'(ec0), STATS ? 32'd1 : 32'd0);
    check("t2_locked", 32'(l0), 32'd1);

    // 3: eight errors at bits 300..307 -> loss of lock, relock 64 bits later
    do_reset();
    gen_reset();
    for (int i = 1; i <= 500; i++) begin
      send(i >= 300 && i <= 307, 1'b0);
      if (i == 306) check("t3_still", 32'(l0), 32'd1);
      if (i == 307) check("t3_loss", 32'(l0), 32'd0);
      if (i == 370) check("t3_hunt", 32'(l0), 32'd0);
      if (i == 371) check("t3_relock", 32'(l0), 32'd1);
    end
    check("t3_errcnt", 32'(ec0), STATS ? 32'd8 : 32'd0);

    // 4: all-zero input never locks
    do_reset();
    for (int i = 0; i < 500; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_lock_seen", 32'(locked_seen0), 32'd0);
    check("t4_pulses", 32'(pulses0), 32'd0);

    // 5: sparse BIT_EN, then reset mid-check and relock
    do_reset();
    gen_reset();
    for (int i = 1; i <= 600; i++) begin
      step(1'b0, 1'b0, 1'($urandom), 1'b0);
      step(1'b0, 1'b0, 1'($urandom), 1'b0);
      send(1'b0, 1'b0);
      if (i == 64) check("t5_lock", 32'(l0), 32'd1);
    end
    check("t5_bitcnt", 32'(bc0), STATS ? 32'd536 : 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t5_rst_out", 32'({15'd0, l0, p0, ec0}), 32'd0);
    check("t5_rst_bc", 32'(bc0), 32'd0);
    for (int i = 1; i <= 100; i++) begin
      step(1'b0, 1'b0, 1'($urandom), 1'b0);
      send(1'b0, 1'b0);
      if (i == 63) check("t5_relock_pre", 32'(l0), 32'd0);
      if (i == 64) check("t5_relock", 32'(l0), 32'd1);
    end
    check("t5_pulses", 32'(pulses0), 32'd0);

    // 6: narrow counters saturate; clear wins over a same-cycle error
    do_reset();
    gen_reset();
    for (int i = 1; i <= 64; i++) send(1'b0, 1'b0);
    for (int i = 1; i <= 200; i++) send(i % 10 == 0, 1'b0);
    check("t6_pulses", 32'(pulses1), 32'd20);
    check("t6_errcnt_sat", 32'(ec1), STATS ? 32'd15 : 32'd0);
    check("t6_locked", 32'(l1), 32'd1);
    send(1'b1, 1'b1);
    check("t6_clr_pulse", 32'(p1), 32'd1);
    check("t6_clr_cnt", 32'({ec1, bc1}), 32'd0);

    // 7: random enables, random errors, random clears
    do_reset();
    gen_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) != 0) send($urandom_range(59) == 0, $urandom_range(199) == 0);
      else step(1'b0, 1'b0, 1'($urandom), $urandom_range(199) == 0);
    end

    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #3;
    check("queue_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
